// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 0 (core) wins by default, port 1 (loader/debug) is force-granted after MAX_WAIT denied cycles.
// Latency: grant and memory command are combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a denied requester holds req/we/addr/wdata until its gnt; read returns cannot be stalled.
//
// Ports:
//   clk, rst_n                    single clock, asynchronous active-low reset
//   pN_req/pN_we/pN_addr/pN_wdata requester command (N = 0, 1)
//   pN_gnt                        command accepted this cycle
//   pN_rvalid, rdata              read return, one cycle after a granted read
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata  synchronous single-port memory
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be in 1..15");
    end

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] starve_cnt;
    logic       starve;
    logic       p0_win;
    logic       p1_win;
    logic [1:0] rd_pend;

    // Port 1 has waited long enough: it takes the slot even if port 0 also asks.
    assign starve = (starve_cnt == WAIT_LIM);

    assign p0_win = p0_req & ~(p1_req & starve);
    assign p1_win = p1_req & ~p0_win;

    // Grants are masked by reset so nothing reaches the memory while rst_n is low.
    assign p0_gnt = rst_n & p0_win;
    assign p1_gnt = rst_n & p1_win;

    assign mem_ce    = p0_gnt | p1_gnt;
    assign mem_we    = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;

    // The memory is synchronous, so the return is simply steered by who issued a read last cycle.
    assign rdata     = mem_rdata;
    assign p0_rvalid = rd_pend[0];
    assign p1_rvalid = rd_pend[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            rd_pend    <= 2'b00;
        end else begin
            // Count consecutive denied cycles of port 1, saturating at the limit.
            if (p1_req && !p1_gnt) begin
                if (starve_cnt != WAIT_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
            rd_pend <= {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .rdata     (rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'hC0DE_0000 + DW'(i);
    endfunction

    // Synchronous memory stub seen by the DUT.
    logic [DW-1:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[7:0]];
        end
    end

    // Reference model state.
    logic [DW-1:0] model_mem [256];
    int            wait_cnt;
    logic          exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd;

    int checks = 0;
    int errors = 0;

    // Observations captured at the falling edge of the most recent cycle.
    logic          obs_g0, obs_g1, obs_ce, obs_we, obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT against the model at negedge, advance the model,
    // then return 1 time unit after the rising edge so the caller can drive new inputs.
    task automatic cycle();
        logic g0, g1;
        @(negedge clk);
        g0 = p0_req && !(p1_req && wait_cnt >= MW);
        g1 = p1_req && !g0;
        obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_ce = mem_ce; obs_we = mem_we;
        obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid; obs_rd = rdata;
        chk("m_p0_gnt", 32'(p0_gnt), 32'(g0));
        chk("m_p1_gnt", 32'(p1_gnt), 32'(g1));
        chk("m_mem_ce", 32'(mem_ce), 32'(g0 | g1));
        chk("m_mem_we", 32'(mem_we), 32'((g0 & p0_we) | (g1 & p1_we)));
        if (g0) begin
            chk("m_addr0", mem_addr, p0_addr);
            if (p0_we) chk("m_wdata0", mem_wdata, p0_wdata);
        end
        if (g1) begin
            chk("m_addr1", mem_addr, p1_addr);
            if (p1_we) chk("m_wdata1", mem_wdata, p1_wdata);
        end
        chk("m_p0_rvalid", 32'(p0_rvalid), 32'(exp_rv0));
        chk("m_p1_rvalid", 32'(p1_rvalid), 32'(exp_rv1));
        if (exp_rv0 || exp_rv1) chk("m_rdata", rdata, exp_rd);
        exp_rv0 = g0 && !p0_we;
        exp_rv1 = g1 && !p1_we;
        if (g0) begin
            if (p0_we) model_mem[p0_addr[7:0]] = p0_wdata;
            else       exp_rd = model_mem[p0_addr[7:0]];
        end
        if (g1) begin
            if (p1_we) model_mem[p1_addr[7:0]] = p1_wdata;
            else       exp_rd = model_mem[p1_addr[7:0]];
        end
        if (p1_req && !g1) wait_cnt = (wait_cnt < MW) ? wait_cnt + 1 : MW;
        else               wait_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    endtask

    typedef struct {
        logic        r0, w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        e_g0, e_g1, e_rv0, e_rv1;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                       input logic g0, input logic g1, input logic rv0, input logic rv1,
                       input logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rd = rd;
        tbl.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = init_val(i);
            model_mem[i] = init_val(i);
        end
        wait_cnt = 0; exp_rv0 = 0; exp_rv1 = 0; exp_rd = '0;

        // Reset state: requests asserted but nothing may be granted.
        rst_n = 0;
        idle_inputs();
        p0_req = 1; p1_req = 1; p1_we = 1;
        #12;
        chk("rst_p0_gnt", 32'(p0_gnt), 0);
        chk("rst_p1_gnt", 32'(p1_gnt), 0);
        chk("rst_mem_ce", 32'(mem_ce), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 0);
        @(posedge clk); #2;
        idle_inputs();
        rst_n = 1;

        // Directed table: single read, write-then-read, alternating reads.
        add(1,0,8'h10,0,          0,0,0,0,              1,0, 0,0, 0);
        add(0,0,0,0,              0,0,0,0,              0,0, 1,0, init_val(16));
        add(0,0,0,0,              1,1,8'h20,32'hDEADBEEF, 0,1, 0,0, 0);
        add(1,0,8'h20,0,          0,0,0,0,              1,0, 0,0, 0);
        add(1,0,8'h00,0,          0,0,0,0,              1,0, 1,0, 32'hDEADBEEF);
        add(0,0,0,0,              1,0,8'h04,0,          0,1, 1,0, init_val(0));
        add(1,0,8'h08,0,          0,0,0,0,              1,0, 0,1, init_val(4));
        add(0,0,0,0,              0,0,0,0,              0,0, 1,0, init_val(8));
        add(0,0,0,0,              0,0,0,0,              0,0, 0,0, 0);
        add(1,1,8'h40,32'h5,      1,0,8'h41,0,          1,0, 0,0, 0);
        add(0,0,0,0,              1,0,8'h41,0,          0,1, 0,0, 0);
        add(0,0,0,0,              0,0,0,0,              0,0, 0,1, init_val(65));
        foreach (tbl[i]) begin
            p0_req = tbl[i].r0; p0_we = tbl[i].w0; p0_addr = AW'(tbl[i].a0); p0_wdata = tbl[i].d0;
            p1_req = tbl[i].r1; p1_we = tbl[i].w1; p1_addr = AW'(tbl[i].a1); p1_wdata = tbl[i].d1;
            cycle();
            chk("tbl_p0_gnt", 32'(obs_g0), 32'(tbl[i].e_g0));
            chk("tbl_p1_gnt", 32'(obs_g1), 32'(tbl[i].e_g1));
            chk("tbl_mem_ce", 32'(obs_ce), 32'(tbl[i].e_g0 | tbl[i].e_g1));
            chk("tbl_p0_rvalid", 32'(obs_rv0), 32'(tbl[i].e_rv0));
            chk("tbl_p1_rvalid", 32'(obs_rv1), 32'(tbl[i].e_rv1));
            if (tbl[i].e_rv0 || tbl[i].e_rv1) chk("tbl_rdata", obs_rd, tbl[i].e_rd);
        end

        // Contention: both ports held; port 1 wins every 5th cycle.
        idle_inputs();
        cycle();
        p0_req = 1; p0_addr = 32'h1; p1_req = 1; p1_addr = 32'h2;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("cont_p0_gnt", 32'(obs_g0), 32'(i % 5 != 4));
            chk("cont_p1_gnt", 32'(obs_g1), 32'(i % 5 == 4));
        end
        idle_inputs();
        cycle();

        // Idle: nothing moves, starvation counter stays at zero.
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("idle_ce", 32'(obs_ce), 0);
            chk("idle_gnt", 32'(obs_g0 | obs_g1), 0);
            chk("idle_rvalid", 32'(obs_rv0 | obs_rv1), 0);
            chk("idle_starve_cnt", 32'(dut.starve_cnt), 0);
        end

        // Reset mid-read: rvalid must vanish immediately and never reappear.
        p0_req = 1; p0_we = 0; p0_addr = 32'h30;
        cycle();
        p0_req = 0;
        chk("mid_p0_rvalid_pre", 32'(p0_rvalid), 1);
        #2 rst_n = 0;
        #1;
        chk("mid_p0_rvalid_rst", 32'(p0_rvalid), 0);
        chk("mid_p1_rvalid_rst", 32'(p1_rvalid), 0);
        p0_req = 1; p1_req = 1;
        #1;
        chk("mid_gnt_rst", 32'(p0_gnt | p1_gnt), 0);
        chk("mid_ce_rst", 32'(mem_ce | mem_we), 0);
        @(posedge clk); #2;
        chk("mid_p0_rvalid_hold", 32'(p0_rvalid), 0);
        idle_inputs();
        rst_n = 1;
        wait_cnt = 0; exp_rv0 = 0; exp_rv1 = 0;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic against the model; requesters hold until granted.
        for (int i = 0; i < 400; i++) begin
            if (!p0_req || obs_g0) begin
                p0_req   = ($urandom_range(0, 99) < 70);
                p0_we    = ($urandom_range(0, 99) < 35);
                p0_addr  = AW'($urandom_range(0, 255));
                p0_wdata = $urandom;
            end
            if (!p1_req || obs_g1) begin
                p1_req   = ($urandom_range(0, 99) < 60);
                p1_we    = ($urandom_range(0, 99) < 35);
                p1_addr  = AW'($urandom_range(0, 255));
                p1_wdata = $urandom;
            end
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
